// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float flag indices and exponent constants
package fpu_pkg;
  localparam int FLAG_DZ = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;
  localparam int EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;
endpackage

// File: rtl/divf_fifo.sv
// divf_fifo: DEPTH x W valid/ready FIFO with occupancy count, zero head when empty
module divf_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 35,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [PTR_W:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready = count != (PTR_W+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
endmodule

// File: rtl/divf_result_stage.sv
// divf_result_stage: patches divf special cases, queues results with flags, keeps sticky flags
module divf_result_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    a,
  input  logic [31:0]    b,
  input  logic [31:0]    s,
  input  logic           ze,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_data,
  output logic [2:0]     out_flags,
  output logic [2:0]     sticky_flags,
  input  logic           flag_clr,
  output logic [PTR_W:0] count
);
  logic sgn, zero_a, ovf, unf, push;
  logic signed [9:0] ext;
  logic [31:0] c_data;
  logic [2:0] c_flags;
  always_comb begin
    sgn = a[31] ^ b[31];
    zero_a = a[30:0] == 31'h0;
    ext = {2'b0, a[30:23]} - {2'b0, b[30:23]} + 10'(EXP_BIAS) - {9'b0, a[22:0] < b[22:0]};
    ovf = ext >= 10'sd255;
    unf = ext <= 10'sd0;
    c_flags = '0;
    c_flags[FLAG_DZ] = ze;
    c_flags[FLAG_OF] = !ze && !zero_a && ovf;
    c_flags[FLAG_UF] = !ze && !zero_a && !ovf && unf;
    c_data = (ze || c_flags[FLAG_OF]) ? (sgn ? NEG_INF : POS_INF) :
             (zero_a || c_flags[FLAG_UF]) ? {sgn, 31'h0} : s;
  end
  assign push = in_valid & in_ready;
  always_ff @(posedge clk)
    sticky_flags <= rst ? 3'b0 : (flag_clr ? 3'b0 : sticky_flags) | (push ? c_flags : 3'b0);
  divf_fifo #(.DEPTH(DEPTH), .W(35)) u_fifo (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({c_data, c_flags}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data({out_data, out_flags}),
    .count(count)
  );
endmodule

// File: tb/tb_divf_result_stage.sv
// tb_divf_result_stage: directed and random checks of divf_result_stage against a queue model
module tb_divf_result_stage;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, flag_clr = 0, ze = 0;
  logic [31:0] a = 0, b = 0, s = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0] out_flags, sticky_flags;
  logic [2:0] count;
  int checks = 0, failures = 0;
  logic [34:0] q[$];
  logic [2:0] m_sticky = 0;

  always #5 clk = ~clk;

  divf_result_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .ze(ze), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .sticky_flags(sticky_flags),
    .flag_clr(flag_clr), .count(count)
  );

  function automatic logic [34:0] classify(input logic [31:0] x, y, q_in, input logic z);
    int e;
    logic sg;
    sg = x[31] ^ y[31];
    e = int'(x[30:23]) - int'(y[30:23]) + 127 - ((x[22:0] < y[22:0]) ? 1 : 0);
    if (z) return {sg, 8'hFF, 23'h0, 3'b100};
    if (x[30:0] == 0) return {sg, 31'h0, 3'b000};
    if (e >= 255) return {sg, 8'hFF, 23'h0, 3'b010};
    if (e <= 0) return {sg, 31'h0, 3'b001};
    return {q_in, 3'b000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp();
    int n;
    n = q.size();
    chk("in_ready", 32'(in_ready), 32'(n != 4));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("count", 32'(count), 32'(n));
    chk("out_data", out_data, n ? q[0][34:3] : 32'h0);
    chk("out_flags", 32'(out_flags), n ? 32'(q[0][2:0]) : 32'h0);
    chk("sticky", 32'(sticky_flags), 32'(m_sticky));
  endtask

  task automatic step();
    logic push, pop;
    logic [34:0] e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_sticky = 0;
    end else begin
      push = in_valid && q.size() != 4;
      pop = out_ready && q.size() != 0;
      e = classify(a, b, s, ze);
      m_sticky = (flag_clr ? 3'b0 : m_sticky) | (push ? e[2:0] : 3'b0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk);
    cmp();
  endtask

  task automatic drive(input logic v, input logic [31:0] x, y, q_in, input logic z);
    in_valid = v; a = x; b = y; s = q_in; ze = z;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 7);
    if (k == 0) v[30:23] = 8'($urandom_range(0, 3));
    if (k == 1) v[30:23] = 8'($urandom_range(250, 255));
    if (k == 2) v[30:0] = 31'h0;
    if (k == 3) v[30:23] = 8'($urandom_range(120, 134));
    return v;
  endfunction

  logic [31:0] vals[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  initial begin
    logic [34:0] r;
    r = classify(32'h40C00000, 32'h40000000, 32'h40400000, 0);
    chk("model_div", r[34:3], 32'h40400000);
    r = classify(32'h7F000000, 32'h00800000, 0, 0);
    chk("model_of", 32'(r), 35'(32'h7F800000) << 3 | 32'd2);
    r = classify(32'h00800000, 32'h7F000000, 0, 0);
    chk("model_uf", 32'(r[2:0]), 32'd1);
    @(negedge clk);
    step();
    rst = 0;
    chk("reset_count", 32'(count), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    drive(1, 32'h40C00000, 32'h40000000, 32'h40400000, 0);
    step();
    chk("div_valid", 32'(out_valid), 1);
    chk("div_data", out_data, 32'h40400000);
    chk("div_flags", 32'(out_flags), 0);
    drive(0, 0, 0, 0, 0); out_ready = 1;
    step();
    drive(1, 32'hBF800000, 32'h0, 32'h12345678, 1); out_ready = 0;
    step();
    chk("dz_data", out_data, 32'hFF800000);
    chk("dz_flags", 32'(out_flags), 32'd4);
    chk("dz_sticky", 32'(sticky_flags), 32'd4);
    drive(0, 0, 0, 0, 0); out_ready = 1; flag_clr = 1;
    step();
    chk("clr_sticky", 32'(sticky_flags), 0);
    drive(1, 32'hBF800000, 32'h0, 0, 1); out_ready = 0;
    step();
    chk("clr_set_sticky", 32'(sticky_flags), 32'd4);
    drive(0, 0, 0, 0, 0); out_ready = 1; flag_clr = 0;
    step();
    drive(1, 32'h7F000000, 32'h00800000, 0, 0); out_ready = 0; flag_clr = 1;
    step();
    flag_clr = 0;
    drive(1, 32'h00800000, 32'h7F000000, 0, 0);
    step();
    chk("of_data", out_data, 32'h7F800000);
    chk("of_flags", 32'(out_flags), 32'd2);
    chk("ofuf_sticky", 32'(sticky_flags), 32'd3);
    drive(0, 0, 0, 0, 0); out_ready = 1;
    step();
    chk("uf_data", out_data, 32'h0);
    chk("uf_flags", 32'(out_flags), 32'd1);
    step();
    drive(1, 32'h80000000, 32'h40000000, 32'h3F000000, 0); out_ready = 0;
    step();
    chk("zero_data", out_data, 32'h80000000);
    chk("zero_flags", 32'(out_flags), 0);
    drive(0, 0, 0, 0, 0); out_ready = 1;
    step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, vals[i], 32'h3F800000, vals[i], 0);
      step();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    chk("full_head", out_data, vals[0]);
    out_ready = 1;
    step();
    chk("pop1_head", out_data, vals[1]);
    chk("pop1_in_ready", 32'(in_ready), 1);
    step();
    chk("fifth_count", 32'(count), 3);
    drive(0, 0, 0, 0, 0);
    step();
    chk("drain_head3", out_data, vals[3]);
    step();
    chk("drain_head4", out_data, vals[4]);
    step();
    out_ready = 0;
    drive(1, vals[0], 32'h3F800000, vals[0], 0); step();
    drive(1, vals[1], 32'h3F800000, vals[1], 0); step();
    drive(1, vals[2], 32'h3F800000, vals[2], 0); out_ready = 1; step();
    chk("wrap_count", 32'(count), 2);
    chk("wrap_head", out_data, vals[1]);
    drive(0, 0, 0, 0, 0); step(); step();
    out_ready = 0; flag_clr = 1;
    drive(1, 32'h7F000000, 32'h00800000, 0, 0); step();
    flag_clr = 0;
    drive(1, 32'h40C00000, 32'h40000000, 32'h40400000, 0); step(); step();
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_sticky", 32'(sticky_flags), 32'd2);
    rst = 1;
    step();
    rst = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sticky", 32'(sticky_flags), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    drive(0, 0, 0, 0, 0);
    step();
    chk("rst_dropped", 32'(out_valid), 0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, rand_op(), rand_op(), $urandom, 0);
      ze = (b[30:0] == 0) || $urandom_range(0, 15) == 0;
      out_ready = $urandom_range(0, 9) < 6;
      flag_clr = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/divf_result_stage.md
Name: divf_result_stage

Overview:
- Registered output stage directly downstream of the combinational float divider `divf`.
- Consumes the divider's raw quotient `s` and divide-by-zero flag `ze`, together with the original operands.
- Replaces the divider's unguarded results (divide by zero, zero dividend, exponent wrap) with IEEE-style special values and per-result exception flags.
- Buffers results in a small valid/ready FIFO and keeps sticky exception flags for the ALU status path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/result set is presented.
- in_ready  output  1  stage can accept; high iff count != DEPTH.
- a  input  32  dividend as given to divf.
- b  input  32  divisor as given to divf.
- s  input  32  divf quotient.
- ze  input  1  divf zero-divisor flag.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  32  corrected quotient at head; 0 when empty.
- out_flags  output  3  head flags, {dz, of, uf}; 0 when empty.
- sticky_flags  output  3  {dz, of, uf}, OR of all accepted entries since the last clear.
- flag_clr  input  1  clears sticky_flags.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Push and pop definitions:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready depends only on count, with no combinational path from out_ready.
- Classification (combinational on inputs, priority order):
  - sgn = a[31]^b[31].
  - ext = 10-bit signed value: {2'b0,a[30:23]} - {2'b0,b[30:23]} + 127 - (a[22:0] < b[22:0] ? 1 : 0).
  - 1) ze=1 -> data {sgn, 8'hFF, 23'h0}, flags 100.
  - 2) a[30:0]==0 -> data {sgn, 31'h0}, flags 000.
  - 3) ext >= 255 -> {sgn, 8'hFF, 23'h0}, flags 010.
  - 4) ext <= 0 -> {sgn, 31'h0}, flags 001 (flush to zero, no denormals).
  - 5) otherwise data = s, flags 000.
- FIFO storage and pointers:
  - Classified {data, flags} is written at wr_ptr on push.
  - Head is read combinationally from rd_ptr.
  - Pointers wrap modulo DEPTH.
  - count is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
- Latency: a push in cycle N on an empty FIFO gives out_valid=1 with that entry in cycle N+1. There is no bypass path.
- Full: in_ready=0, and any in_valid is ignored with no state change. A pop while full raises in_ready the next cycle.
- Empty: out_valid=0, out_data=0, out_flags=0, and out_ready is ignored.
- Ordering: strict FIFO. out_data and out_flags are held stable while out_valid & !out_ready.
- Sticky flags:
  - Next value = (flag_clr ? 0 : sticky) | (push ? entry_flags : 0).
  - When set and clear occur in the same cycle, the set wins.
- Reset (synchronous, highest priority, including mid-operation):
  - wr_ptr, rd_ptr, count and sticky_flags go to 0.
  - out_valid=0, out_data=0, out_flags=0, in_ready=1 in the cycle after rst is sampled.
  - Stored entries are discarded, and a push coinciding with rst is dropped.
- No other state exists; memory contents need no reset.

Decomposition:
- Package fpu_pkg holds:
  - FLAG_DZ/FLAG_OF/FLAG_UF bit indices.
  - EXP_BIAS=127 and EXP_MAX=8'hFF.
  - Helper constants POS_INF=32'h7F800000 and NEG_INF=32'hFF800000.
- One natural sub-module, divf_fifo: a generic DEPTH x W valid/ready FIFO with pointers, count, full/empty.
- Classification logic stays in the top.

Test Plan:
- 6.0/2.0: a=40C00000, b=40000000, s=40400000, ze=0, pushed at cycle N -> out_valid at N+1, out_data=40400000, out_flags=000, sticky=000.
- Divide by zero: a=BF800000, b=00000000, ze=1 -> out_data=FF800000, out_flags=100, sticky=100. Then flag_clr alone -> sticky=000. Then flag_clr together with another dz push -> sticky=100.
- Overflow/underflow:
  - a=7F000000, b=00800000 (ext=380) -> 7F800000, flags 010.
  - a=00800000, b=7F000000 (ext=-126) -> 00000000, flags 001.
  - sticky=011 after both.
- Zero dividend: a=80000000, b=40000000, s=arbitrary (e.g. 3F000000) -> out_data=80000000, flags 000.
- Full/backpressure:
  - Setup: out_ready=0, five pushes of distinct valid quotients 3F800000, 40000000, 40400000, 40800000, 40A00000.
  - Expected while blocked: in_ready=0 after the fourth push, count=4, fifth held upstream.
  - Release: raise out_ready -> values drain in order, with the fifth accepted the cycle after the first pop.
  - Wrap check: a simultaneous push and pop at count=2 keeps count=2 and wraps pointers correctly.
- Reset mid-stream: with count=3 and sticky=010, assert rst for 1 cycle (plus an in_valid the same cycle) -> next cycle count=0, out_valid=0, out_data=0, sticky=000, in_ready=1, and the dropped push never appears.
